instr_fetch_issue: RTL and testbench

Front end of the 16-bit processor. It owns the program counter and fetches one 16-bit instruction at a time from instruction memory over a req/ack handshake. It presents the instruction and its opcode[15:12] to the control/decode stage over a valid/ready handshake. It accepts PC redirects (taken branch, jump) from execute and squashes any wrong-path fetch. It flags unsupported opcodes and halts on them.

---
 rtl/instr_fetch_issue.sv | 142 ++++++++++++++
 tb/tb_instr_fetch_issue.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_issue.sv
// Front end of the 16-bit core: PC, instruction fetch over req/ack,
// issue to decode over valid/ready, redirect squash and illegal-opcode halt.
module instr_fetch_issue #(
  parameter int          ADDR_W     = 16,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  MAX_OPCODE = 4'b0100
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [15:0]       instr,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] req_addr, req_addr_n;
  logic              discard, discard_n;
  logic              gap, gap_n;
  logic [15:0]       instr_n;
  logic [ADDR_W-1:0] instr_pc_n;
  logic              fault_n;
  logic [ADDR_W-1:0] fault_pc_n;
  logic              ack;
  logic [ADDR_W-1:0] pc_inc;

  // gap holds the request low for one cycle (after reset or a dropped ack)
  assign imem_req    = (state == REQ) && !gap;
  assign imem_addr   = imem_req ? req_addr : '0;
  assign instr_valid = (state == ISSUE);
  assign opcode      = instr[15:12];
  assign ack         = imem_req && imem_ack;
  assign pc_inc      = instr_pc + ADDR_W'(1);

  // state register; an ack seen while reset=1 is ignored
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= REQ;
      pc       <= ADDR_W'(RESET_PC);
      req_addr <= ADDR_W'(RESET_PC);
      discard  <= 1'b0;
      gap      <= 1'b1;
      instr    <= '0;
      instr_pc <= '0;
      fault    <= 1'b0;
      fault_pc <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      discard  <= discard_n;
      gap      <= gap_n;
      instr    <= instr_n;
      instr_pc <= instr_pc_n;
      fault    <= fault_n;
      fault_pc <= fault_pc_n;
    end
  end

  // next state: redirect outranks ack and handshake; HALT is terminal
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    discard_n  = discard;
    gap_n      = gap;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    fault_n    = fault;
    fault_pc_n = fault_pc;
    case (state)
      REQ: begin
        if (gap) begin
          gap_n = 1'b0;
          if (redirect_valid) begin
            pc_n       = redirect_target;
            req_addr_n = redirect_target;
          end
        end else if (redirect_valid) begin
          pc_n = redirect_target;
          if (ack) begin
            gap_n      = 1'b1;
            discard_n  = 1'b0;
            req_addr_n = redirect_target;
          end else begin
            discard_n = 1'b1;
          end
        end else if (ack) begin
          if (discard) begin
            discard_n  = 1'b0;
            gap_n      = 1'b1;
            req_addr_n = pc;
          end else begin
            instr_n    = imem_rdata;
            instr_pc_n = req_addr;
            if (imem_rdata[15:12] > MAX_OPCODE) begin
              fault_n    = 1'b1;
              fault_pc_n = req_addr;
              state_n    = HALT;
            end else begin
              state_n = ISSUE;
            end
          end
        end
      end
      ISSUE: begin
        if (redirect_valid) begin
          pc_n       = redirect_target;
          req_addr_n = redirect_target;
          state_n    = REQ;
        end else if (instr_ready) begin
          pc_n       = pc_inc;
          req_addr_n = pc_inc;
          state_n    = REQ;
        end
      end
      HALT: begin
        state_n = HALT;
      end
      default: begin
        state_n = HALT;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_issue.sv
// Directed bench for instr_fetch_issue with an issue scoreboard;
// second instance checks PC wrap with RESET_PC=16'hFFFF.
module tb_instr_fetch_issue;

  typedef struct packed {
    logic [15:0] ins;
    logic [15:0] pc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset, ack, rdy, rv;
  logic [15:0] rdata, tgt;
  logic        req, valid, fault;
  logic [15:0] addr, instr, ipc, fpc;
  logic [3:0]  opc;

  logic        wreset, wack, wrdy, wrv;
  logic [15:0] wrdata, wtgt;
  logic        wreq, wvalid, wfault;
  logic [15:0] waddr, winstr, wipc, wfpc;
  logic [3:0]  wopc;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  instr_fetch_issue dut (
    .clock(clock), .reset(reset),
    .imem_req(req), .imem_addr(addr),
    .imem_ack(ack), .imem_rdata(rdata),
    .instr_valid(valid), .instr_ready(rdy),
    .instr(instr), .opcode(opc), .instr_pc(ipc),
    .redirect_valid(rv), .redirect_target(tgt),
    .fault(fault), .fault_pc(fpc)
  );

  instr_fetch_issue #(.RESET_PC(16'hFFFF)) dutw (
    .clock(clock), .reset(wreset),
    .imem_req(wreq), .imem_addr(waddr),
    .imem_ack(wack), .imem_rdata(wrdata),
    .instr_valid(wvalid), .instr_ready(wrdy),
    .instr(winstr), .opcode(wopc), .instr_pc(wipc),
    .redirect_valid(wrv), .redirect_target(wtgt),
    .fault(wfault), .fault_pc(wfpc)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] oi,
                         input logic [15:0] op);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, oi, e.ins);
      chk({tag, "_pc"}, op, e.pc);
    end
  endtask

  initial begin
    reset = 1; ack = 0; rdy = 0; rv = 0; rdata = 0; tgt = 0;
    wreset = 1; wack = 0; wrdy = 0; wrv = 0; wrdata = 0; wtgt = 0;
    step(); step();
    chk("rst_req", req, 0);
    chk("rst_addr", addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_ipc", ipc, 0);
    chk("rst_fault", fault, 0);
    chk("rst_fpc", fpc, 0);
    reset = 0;
    chk("rst_hold_req", req, 0);
    step();
    chk("first_req", req, 1);
    chk("first_addr", addr, 16'h0000);
    step();
    ack = 1; rdata = 16'h1234; sb.push_back('{16'h1234, 16'h0000});
    step(); ack = 0;
    chk("basic_valid", valid, 1);
    chk("basic_opc", opc, 4'h1);
    chk("basic_req", req, 0);
    pop_chk("basic", instr, ipc);
    rdy = 1; step(); rdy = 0;
    chk("basic_next_req", req, 1);
    chk("basic_next_addr", addr, 16'h0001);
    chk("basic_valid_drop", valid, 0);

    ack = 1; rdata = 16'h2005; sb.push_back('{16'h2005, 16'h0001});
    step(); ack = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_valid", valid, 1);
      chk("bp_instr", instr, 16'h2005);
      chk("bp_opc", opc, 4'h2);
      chk("bp_ipc", ipc, 16'h0001);
      chk("bp_req", req, 0);
    end
    pop_chk("bp", instr, ipc);
    rdy = 1; step(); rdy = 0;
    chk("bp_one_hs", valid, 0);
    chk("bp_next_addr", addr, 16'h0002);

    rv = 1; tgt = 16'h0005; step(); rv = 0;
    chk("rd_inflight_req", req, 1);
    chk("rd_inflight_addr", addr, 16'h0002);
    ack = 1; rdata = 16'h1111; step(); ack = 0;
    chk("rd_drop_gap", req, 0);
    chk("rd_drop_valid", valid, 0);
    step();
    chk("rd5_req", req, 1);
    chk("rd5_addr", addr, 16'h0005);
    rv = 1; tgt = 16'h0040; step(); rv = 0;
    chk("rd40_hold_addr", addr, 16'h0005);
    step();
    ack = 1; rdata = 16'h3333; step(); ack = 0;
    chk("rd40_no_valid", valid, 0);
    chk("rd40_gap", req, 0);
    step();
    chk("rd40_req", req, 1);
    chk("rd40_addr", addr, 16'h0040);
    chk("rd40_valid", valid, 0);

    ack = 1; rdata = 16'h4444; rv = 1; tgt = 16'h0007;
    step(); ack = 0; rv = 0;
    chk("rdack_valid", valid, 0);
    chk("rdack_gap", req, 0);
    step();
    chk("rdack_addr", addr, 16'h0007);
    ack = 1; rdata = 16'h1007; sb.push_back('{16'h1007, 16'h0007});
    step(); ack = 0;
    chk("rdhs_valid", valid, 1);
    pop_chk("rdhs", instr, ipc);
    rdy = 1; rv = 1; tgt = 16'h0100; step(); rdy = 0; rv = 0;
    chk("rdhs_drop", valid, 0);
    chk("rdhs_addr", addr, 16'h0100);

    ack = 1; rdata = 16'h4000; sb.push_back('{16'h4000, 16'h0100});
    step(); ack = 0;
    chk("op4_valid", valid, 1);
    chk("op4_fault", fault, 0);
    pop_chk("op4", instr, ipc);
    rv = 1; tgt = 16'h0003; step(); rv = 0;
    chk("iss_rd_valid", valid, 0);
    chk("iss_rd_addr", addr, 16'h0003);
    ack = 1; rdata = 16'hA000; step(); ack = 0;
    chk("ill_fault", fault, 1);
    chk("ill_fpc", fpc, 16'h0003);
    chk("ill_valid", valid, 0);
    chk("ill_req", req, 0);
    chk("ill_opc", opc, 4'hA);
    rv = 1; tgt = 16'h0000; step(); rv = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_req", req, 0);
      chk("halt_valid", valid, 0);
      chk("halt_fault", fault, 1);
      chk("halt_fpc", fpc, 16'h0003);
    end
    reset = 1; step(); reset = 0;
    chk("clr_fault", fault, 0);
    chk("clr_fpc", fpc, 0);
    step();
    chk("op5_addr", addr, 16'h0000);
    ack = 1; rdata = 16'h5000; step(); ack = 0;
    chk("op5_fault", fault, 1);
    chk("op5_valid", valid, 0);

    wreset = 0; step();
    chk("w_req", wreq, 1);
    chk("w_addr", waddr, 16'hFFFF);
    wack = 1; wrdata = 16'h2ABC; sb.push_back('{16'h2ABC, 16'hFFFF});
    step(); wack = 0;
    chk("w_valid", wvalid, 1);
    pop_chk("w", winstr, wipc);
    wrdy = 1; step(); wrdy = 0;
    chk("w_wrap_addr", waddr, 16'h0000);
    wreset = 1; wack = 1; wrdata = 16'h1000; step(); wack = 0;
    chk("w_rst_req", wreq, 0);
    chk("w_rst_valid", wvalid, 0);
    chk("w_rst_ipc", wipc, 0);
    wreset = 0; step();
    chk("w_restart_req", wreq, 1);
    chk("w_restart_addr", waddr, 16'hFFFF);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
